// File: rtl/assoc_dcache_pkg.sv
// Shared definitions for the set-associative data cache: controller states,
// width helper and the derived geometry of the default configuration.
package assoc_dcache_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WRITEBACK = 2'd1,
      ST_FETCH     = 2'd2,
      ST_UPDATE    = 2'd3
   } state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   localparam int OFF_W = clog2(4);
   localparam int IDX_W = clog2(4);
   localparam int TAG_W = 8 - OFF_W - IDX_W;
   localparam int BLK_W = 4 * 8;

endpackage

// File: rtl/assoc_dcache_way.sv
// One way of the cache: per-set tag, valid, dirty and block storage with a
// combinational lookup port, a word-write port and a block-fill port.
module dcache_way
   import assoc_dcache_pkg::*;
#(
   parameter int SETS   = 4,
   parameter int DATA_W = 8,
   parameter int OFF_B  = OFF_W,
   parameter int IDX_B  = IDX_W,
   parameter int TAG_B  = TAG_W,
   parameter int BLK_B  = BLK_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_B-1:0] idx,
   input  logic [TAG_B-1:0] tag,
   input  logic [OFF_B-1:0] off,
   input  logic             wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic             fill_en,
   input  logic [IDX_B-1:0] fill_idx,
   input  logic [TAG_B-1:0] fill_tag,
   input  logic [BLK_B-1:0] fill_blk,
   output logic             hit,
   output logic             valid,
   output logic             dirty,
   output logic [TAG_B-1:0] line_tag,
   output logic [BLK_B-1:0] line
);

   logic [SETS-1:0]  valid_r;
   logic [SETS-1:0]  dirty_r;
   logic [TAG_B-1:0] tag_r  [SETS];
   logic [BLK_B-1:0] data_r [SETS];

   // Line state bits; a fill always leaves the line clean.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r <= '0;
         dirty_r <= '0;
      end else if (fill_en) begin
         valid_r[fill_idx] <= 1'b1;
         dirty_r[fill_idx] <= 1'b0;
      end else if (wr_en) begin
         dirty_r[idx] <= 1'b1;
      end
   end

   // Tag and data arrays are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (fill_en) begin
         tag_r[fill_idx]  <= fill_tag;
         data_r[fill_idx] <= fill_blk;
      end else if (wr_en) begin
         data_r[idx][off*DATA_W +: DATA_W] <= wr_data;
      end
   end

   assign valid    = valid_r[idx];
   assign dirty    = dirty_r[idx];
   assign line_tag = tag_r[idx];
   assign line     = data_r[idx];
   assign hit      = valid_r[idx] & (tag_r[idx] == tag);

endmodule

// File: rtl/assoc_dcache.sv
// Write-back, write-allocate N-way data cache with LRU replacement and
// saturating hit/miss counters between the CPU port and block memory.
module assoc_dcache
   import assoc_dcache_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int WORDS  = 4,
   parameter int SETS   = 4,
   parameter int WAYS   = 2,
   parameter int CNT_W  = 16
) (
   input  logic                              CLK,
   input  logic                              RESET,
   input  logic                              READ,
   input  logic                              WRITE,
   input  logic [ADDR_W-1:0]                 ADDRESS,
   input  logic [DATA_W-1:0]                 WRITEDATA,
   output logic [DATA_W-1:0]                 READDATA,
   output logic                              BUSYWAIT,
   output logic                              M_READ,
   output logic                              M_WRITE,
   output logic [ADDR_W-clog2(WORDS)-1:0]    M_ADDRESS,
   output logic [WORDS*DATA_W-1:0]           M_WRITEDATA,
   input  logic [WORDS*DATA_W-1:0]           M_READDATA,
   input  logic                              M_BUSYWAIT,
   output logic [CNT_W-1:0]                  HIT_COUNT,
   output logic [CNT_W-1:0]                  MISS_COUNT
);

   localparam int OFF_B = clog2(WORDS);
   localparam int IDX_B = clog2(SETS);
   localparam int TAG_B = ADDR_W - OFF_B - IDX_B;
   localparam int BLK_B = WORDS * DATA_W;

   logic [OFF_B-1:0] off_s;
   logic [IDX_B-1:0] idx_s;
   logic [TAG_B-1:0] tag_s;
   logic [WAYS-1:0]  hit_s, valid_s, dirty_s, wr_en_s, fill_en_s;
   logic [TAG_B-1:0] way_tag_s  [WAYS];
   logic [BLK_B-1:0] way_line_s [WAYS];
   logic             hit_any_s, req_s, hit_way_s, victim_s;

   state_t              state_r;
   logic                m_read_r, m_write_r, victim_r, refill_r;
   logic [TAG_B+IDX_B-1:0] m_addr_r;
   logic [BLK_B-1:0]    m_wdata_r, fill_blk_r;
   logic [TAG_B-1:0]    miss_tag_r;
   logic [IDX_B-1:0]    miss_idx_r;
   logic [SETS-1:0]     lru_r;
   logic [CNT_W-1:0]    hit_cnt_r, miss_cnt_r;

   assign off_s = ADDRESS[OFF_B-1:0];
   assign idx_s = ADDRESS[OFF_B +: IDX_B];
   assign tag_s = ADDRESS[ADDR_W-1 -: TAG_B];

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      assign wr_en_s[w]   = (state_r == ST_IDLE) & WRITE & hit_s[w];
      assign fill_en_s[w] = (state_r == ST_UPDATE) & (victim_r == 1'(w));

      dcache_way #(
         .SETS(SETS), .DATA_W(DATA_W), .OFF_B(OFF_B),
         .IDX_B(IDX_B), .TAG_B(TAG_B), .BLK_B(BLK_B)
      ) u_way (
         .clk(CLK), .rst_n(RESET),
         .idx(idx_s), .tag(tag_s), .off(off_s),
         .wr_en(wr_en_s[w]), .wr_data(WRITEDATA),
         .fill_en(fill_en_s[w]), .fill_idx(miss_idx_r),
         .fill_tag(miss_tag_r), .fill_blk(fill_blk_r),
         .hit(hit_s[w]), .valid(valid_s[w]), .dirty(dirty_s[w]),
         .line_tag(way_tag_s[w]), .line(way_line_s[w])
      );
   end

   assign hit_any_s = |hit_s;
   assign req_s     = READ | WRITE;

   // Hit way, victim choice (lowest invalid way wins over LRU) and load data.
   always_comb begin
      hit_way_s = 1'b0;
      victim_s  = (WAYS == 2) ? lru_r[idx_s] : 1'b0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (hit_s[w]) hit_way_s = 1'(w);
         else          hit_way_s = hit_way_s;
         if (!valid_s[w]) victim_s = 1'(w);
         else             victim_s = victim_s;
      end
      if (hit_any_s) READDATA = way_line_s[hit_way_s][off_s*DATA_W +: DATA_W];
      else           READDATA = '0;
      if (state_r == ST_IDLE) BUSYWAIT = req_s & ~hit_any_s;
      else                    BUSYWAIT = 1'b1;
   end

   // Miss-handling controller, LRU state and performance counters.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_r    <= ST_IDLE;
         m_read_r   <= 1'b0;
         m_write_r  <= 1'b0;
         m_addr_r   <= '0;
         m_wdata_r  <= '0;
         fill_blk_r <= '0;
         miss_tag_r <= '0;
         miss_idx_r <= '0;
         victim_r   <= 1'b0;
         refill_r   <= 1'b0;
         lru_r      <= '0;
         hit_cnt_r  <= '0;
         miss_cnt_r <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               refill_r <= 1'b0;
               if (req_s && hit_any_s) begin
                  // The first hit after a refill is the same request that missed.
                  if (!refill_r && hit_cnt_r != '1) hit_cnt_r <= hit_cnt_r + 1'b1;
                  if (WAYS == 2) lru_r[idx_s] <= ~hit_way_s;
               end else if (req_s) begin
                  if (miss_cnt_r != '1) miss_cnt_r <= miss_cnt_r + 1'b1;
                  miss_tag_r <= tag_s;
                  miss_idx_r <= idx_s;
                  victim_r   <= victim_s;
                  if (valid_s[victim_s] && dirty_s[victim_s]) begin
                     state_r   <= ST_WRITEBACK;
                     m_write_r <= 1'b1;
                     m_addr_r  <= {way_tag_s[victim_s], idx_s};
                     m_wdata_r <= way_line_s[victim_s];
                  end else begin
                     state_r  <= ST_FETCH;
                     m_read_r <= 1'b1;
                     m_addr_r <= {tag_s, idx_s};
                  end
               end
            end
            ST_WRITEBACK: begin
               if (!M_BUSYWAIT) begin
                  state_r   <= ST_FETCH;
                  m_write_r <= 1'b0;
                  m_read_r  <= 1'b1;
                  m_addr_r  <= {miss_tag_r, miss_idx_r};
               end
            end
            ST_FETCH: begin
               if (!M_BUSYWAIT) begin
                  state_r    <= ST_UPDATE;
                  m_read_r   <= 1'b0;
                  fill_blk_r <= M_READDATA;
               end
            end
            ST_UPDATE: begin
               state_r  <= ST_IDLE;
               refill_r <= 1'b1;
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

   assign M_READ      = m_read_r;
   assign M_WRITE     = m_write_r;
   assign M_ADDRESS   = m_addr_r;
   assign M_WRITEDATA = m_wdata_r;
   assign HIT_COUNT   = hit_cnt_r;
   assign MISS_COUNT  = miss_cnt_r;

endmodule

// File: tb/tb_assoc_dcache.sv
// Randomized bench for assoc_dcache against an LRU-list cache model and a
// byte-level architectural memory image, with a 5-cycle block memory.
module tb_assoc_dcache;

   logic        CLK = 1'b0;
   logic        RESET, READ, WRITE, M_BUSYWAIT;
   logic [7:0]  ADDRESS, WRITEDATA, READDATA;
   logic        BUSYWAIT, M_READ, M_WRITE;
   logic [5:0]  M_ADDRESS;
   logic [31:0] M_WRITEDATA, M_READDATA;
   logic [15:0] HIT_COUNT, MISS_COUNT;

   assoc_dcache dut (
      .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
      .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
      .BUSYWAIT(BUSYWAIT), .M_READ(M_READ), .M_WRITE(M_WRITE),
      .M_ADDRESS(M_ADDRESS), .M_WRITEDATA(M_WRITEDATA),
      .M_READDATA(M_READDATA), .M_BUSYWAIT(M_BUSYWAIT),
      .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
   );

   always #5 CLK = ~CLK;

   logic [7:0] mem  [256];
   logic [7:0] arch [256];
   logic [1:0] req_q = 2'b00;
   int         lat_cnt = 0;

   // Memory releases busywait after a request has been held for 5 cycles.
   always @(posedge CLK) begin
      req_q <= {M_READ, M_WRITE};
      if ({M_READ, M_WRITE} != req_q) lat_cnt <= 0;
      else if (M_READ || M_WRITE)     lat_cnt <= lat_cnt + 1;
   end
   assign M_BUSYWAIT = (M_READ || M_WRITE) && !(({M_READ, M_WRITE} == req_q) && lat_cnt >= 4);

   always_comb begin
      for (int i = 0; i < 4; i++) M_READDATA[i*8 +: 8] = mem[{M_ADDRESS, 2'(i)}];
   end

   int n_cmp = 0;
   int n_err = 0;
   int res [4][2];
   int cnt [4];
   bit dirty [64];
   int hits, misses;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < 4; s++) cnt[s] = 0;
      for (int b = 0; b < 64; b++) dirty[b] = 1'b0;
      for (int a = 0; a < 256; a++) arch[a] = mem[a];
      hits = 0;
      misses = 0;
   endtask

   task automatic do_op(input bit wr, input logic [7:0] addr, input logic [7:0] wdata, input bit both);
      int blk, s, pos, victim;
      bit exp_wb, saw_wb, saw_rd, done;
      logic [31:0] vblk;
      blk = int'(addr) >> 2;
      s = blk % 4;
      pos = -1;
      for (int i = 0; i < cnt[s]; i++) if (res[s][i] == blk) pos = i;
      exp_wb = 1'b0;
      victim = 0;
      vblk = '0;
      if (pos < 0 && cnt[s] == 2) begin
         victim = res[s][0];
         exp_wb = dirty[victim];
         for (int i = 0; i < 4; i++) vblk[i*8 +: 8] = arch[victim*4 + i];
      end
      @(negedge CLK);
      ADDRESS = addr; WRITEDATA = wdata; WRITE = wr; READ = !wr || both;
      #1 chk("busywait", BUSYWAIT, pos < 0);
      if (pos < 0) begin
         saw_wb = 1'b0; saw_rd = 1'b0; done = 1'b0;
         for (int c = 0; c < 200 && !done; c++) begin
            @(negedge CLK);
            chk("rd_wr_excl", M_READ & M_WRITE, 1'b0);
            if (M_WRITE && !saw_wb) begin
               saw_wb = 1'b1;
               chk("wb_addr", M_ADDRESS, victim);
               chk("wb_data", M_WRITEDATA, vblk);
            end
            if (M_WRITE && !M_BUSYWAIT)
               for (int i = 0; i < 4; i++) mem[{M_ADDRESS, 2'(i)}] = M_WRITEDATA[i*8 +: 8];
            if (M_READ && !saw_rd) begin
               saw_rd = 1'b1;
               chk("fetch_addr", M_ADDRESS, blk);
               chk("wb_before_fetch", saw_wb, exp_wb);
            end
            done = !BUSYWAIT;
         end
         chk("miss_done", done, 1'b1);
         chk("wb_seen", saw_wb, exp_wb);
         chk("fetch_seen", saw_rd, 1'b1);
      end
      if (!wr) chk("readdata", READDATA, arch[addr]);
      if (pos >= 0) begin
         hits = (hits == 65535) ? 65535 : hits + 1;
         for (int i = pos; i < cnt[s] - 1; i++) res[s][i] = res[s][i+1];
         res[s][cnt[s]-1] = blk;
      end else begin
         misses = (misses == 65535) ? 65535 : misses + 1;
         if (cnt[s] == 2) begin
            dirty[victim] = 1'b0;
            res[s][0] = res[s][1];
            cnt[s] = 1;
         end
         res[s][cnt[s]] = blk;
         cnt[s]++;
      end
      if (wr) begin
         arch[addr] = wdata;
         dirty[blk] = 1'b1;
      end
      @(posedge CLK);
      #1;
      chk("hit_count", HIT_COUNT, hits);
      chk("miss_count", MISS_COUNT, misses);
      READ = 1'b0; WRITE = 1'b0;
   endtask

   initial begin
      int needed, blk;
      RESET = 1'b0; READ = 1'b0; WRITE = 1'b0; ADDRESS = 8'h00; WRITEDATA = 8'h00;
      for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
      model_reset();
      #1;
      chk("rst_busywait", BUSYWAIT, 1'b0);
      chk("rst_m_read", M_READ, 1'b0);
      chk("rst_m_write", M_WRITE, 1'b0);
      chk("rst_hits", HIT_COUNT, 16'h0000);
      chk("rst_misses", MISS_COUNT, 16'h0000);
      repeat (3) @(negedge CLK);
      RESET = 1'b1;

      // Directed sequence: cold miss, hit, dirty eviction of set 0, survivor hit.
      do_op(1'b0, 8'h00, 8'h00, 1'b0);
      do_op(1'b0, 8'h01, 8'h00, 1'b0);
      do_op(1'b1, 8'h00, 8'hAB, 1'b0);
      do_op(1'b0, 8'h10, 8'h00, 1'b0);
      do_op(1'b0, 8'h20, 8'h00, 1'b0);
      do_op(1'b0, 8'h10, 8'h00, 1'b0);
      do_op(1'b0, 8'h30, 8'h00, 1'b0);

      for (int n = 0; n < 300; n++) begin
         blk = int'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) blk = int'($urandom_range(0, 63));
         do_op(1'($urandom_range(0, 1)), 8'(blk * 4 + int'($urandom_range(0, 3))),
               8'($urandom), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) @(negedge CLK);
      end

      // Reset during FETCH: requests drop at once and dirty data is lost.
      @(negedge CLK);
      RESET = 1'b0;
      @(negedge CLK);
      RESET = 1'b1;
      model_reset();
      @(negedge CLK);
      ADDRESS = 8'h40; READ = 1'b1;
      for (int i = 0; i < 50 && !M_READ; i++) @(negedge CLK);
      chk("fetch_before_reset", M_READ, 1'b1);
      @(negedge CLK);
      RESET = 1'b0; READ = 1'b0;
      #1;
      chk("midrst_m_read", M_READ, 1'b0);
      chk("midrst_busywait", BUSYWAIT, 1'b0);
      chk("midrst_misses", MISS_COUNT, 16'h0000);
      @(negedge CLK);
      RESET = 1'b1;
      model_reset();
      do_op(1'b0, 8'h40, 8'h00, 1'b0);
      do_op(1'b1, 8'h44, 8'h5A, 1'b0);

      // Saturate the hit counter with back-to-back hits.
      needed = 65535 - hits + 3;
      @(negedge CLK);
      ADDRESS = 8'h41; READ = 1'b1;
      repeat (needed) @(posedge CLK);
      #1;
      hits = 65535;
      chk("hit_saturated", HIT_COUNT, 16'hFFFF);
      chk("miss_unaffected", MISS_COUNT, misses);
      READ = 1'b0;
      do_op(1'b0, 8'h42, 8'h00, 1'b0);
      do_op(1'b0, 8'h84, 8'h00, 1'b0);
      do_op(1'b0, 8'h45, 8'h00, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/assoc_dcache.md
Name: assoc_dcache

Overview:
- Parametrised N-way (1 or 2) set-associative, write-back, write-allocate data cache.
- Sits between the CPU load/store port and the word-block data memory.
- Generalises the fixed 8-line direct-mapped data cache in width, depth, block size and associativity.
- Adds LRU replacement and saturating hit/miss performance counters.

Parameters:
- ADDR_W, 8, CPU byte-address width.
- DATA_W, 8, CPU data width.
- WORDS, 4, data words per block (power of 2, ≥2).
- SETS, 4, sets (power of 2).
- WAYS, 2, associativity; legal values 1 or 2.
- CNT_W, 16, width of the performance counters.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- READ  in  1  CPU read request.
- WRITE  in  1  CPU write request.
- ADDRESS  in  ADDR_W  CPU address.
- WRITEDATA  in  DATA_W  CPU store data.
- READDATA  out  DATA_W  load data to CPU.
- BUSYWAIT  out  1  stall to CPU.
- M_READ  out  1  block read request to memory.
- M_WRITE  out  1  block write request to memory.
- M_ADDRESS  out  ADDR_W-log2(WORDS)  block address to memory.
- M_WRITEDATA  out  WORDS*DATA_W  victim block to memory.
- M_READDATA  in  WORDS*DATA_W  fill block from memory.
- M_BUSYWAIT  in  1  memory busy.
- HIT_COUNT  out  CNT_W  saturating hit counter.
- MISS_COUNT  out  CNT_W  saturating miss counter.

Behaviour:
- Address split: offset = low log2(WORDS) bits; index = next log2(SETS) bits; tag = remaining bits. Word i of a block occupies block bits [i*DATA_W +: DATA_W].
- Reset (RESET=0, asynchronous): all valid, dirty and LRU bits cleared; FSM to IDLE; M_READ=0, M_WRITE=0, BUSYWAIT=0, HIT_COUNT=0, MISS_COUNT=0. Data and tag arrays are not cleared.
- Reset mid-miss: memory requests drop immediately. Dirty data is discarded by design.
- Hit: some way in the indexed set is valid and its tag equals the address tag. Evaluated combinationally.
- States: IDLE, WRITEBACK, FETCH, UPDATE.
- IDLE:
  - BUSYWAIT = (READ|WRITE) & ~hit.
  - Read hit: READDATA is driven combinationally in the same cycle, with zero stall.
  - Write hit: the word is written at the rising edge; the line is marked dirty.
  - Any hit sets LRU[set] to point at the other way (no-op when WAYS=1).
  - READ and WRITE asserted together: treated as WRITE.
- Victim selection: the lowest-numbered invalid way; otherwise the way given by LRU[set].
- Miss from IDLE: if the victim is valid and dirty, go to WRITEBACK; otherwise go to FETCH.
- WRITEBACK:
  - M_WRITE=1, M_ADDRESS={victim tag, index}, M_WRITEDATA = victim block.
  - Stays until M_BUSYWAIT is sampled 0 with M_WRITE high, then goes to FETCH.
- FETCH:
  - M_READ=1, M_ADDRESS={tag, index}.
  - On M_BUSYWAIT=0, latches M_READDATA and goes to UPDATE.
- UPDATE: writes the block, tag, valid=1 and dirty=0 into the victim way, then goes to IDLE. The request now hits; a write hit then sets dirty.
- BUSYWAIT is 1 in WRITEBACK, FETCH and UPDATE.
- M_READ and M_WRITE are never both 1, and both are 0 in IDLE and UPDATE.
- Counters:
  - MISS_COUNT increments once on each IDLE-to-miss transition.
  - HIT_COUNT increments on IDLE hits, excluding the first hit following UPDATE (same request; tracked with a refill flag).
  - Both saturate at all-ones.
- A request deasserted mid-miss still completes the fill. The line is installed and no CPU write occurs.
- WAYS=1: degenerates to direct-mapped; LRU is unused and the victim is always way 0.

Decomposition:
- Shared package/header:
  - FSM state encoding (IDLE=0, WRITEBACK=1, FETCH=2, UPDATE=3).
  - Derived localparams OFF_W, IDX_W, TAG_W, BLK_W.
  - clog2 helper function.
- One sub-module, dcache_way: tag/valid/dirty/data storage for one way.
  - Outputs: hit, line data, dirty bit.
  - Inputs: write-word and fill-block ports.
  - Instantiated WAYS times from the top.

Test Plan (WAYS=2, SETS=4, WORDS=4, 5-cycle memory latency):
- Reset, read 0x00 -> BUSYWAIT=1 through FETCH and UPDATE, M_READ=1 with M_ADDRESS=0x00, READDATA = memory byte 0; MISS_COUNT=1, HIT_COUNT=0.
- Read 0x01 next -> zero-stall hit, READDATA = memory byte 1; HIT_COUNT=1.
- Write 0xAB to 0x00; read 0x10; read 0x20 (all set 0) -> the 0x20 miss evicts the LRU way holding dirty 0x00. This asserts M_WRITE with M_ADDRESS=0x00 and M_WRITEDATA[7:0]=0xAB before M_READ with M_ADDRESS=0x08.
- After the previous case, read 0x10 -> hit (the way holding 0x10 survived); LRU now points at the way holding 0x20.
- Assert RESET=0 during FETCH -> M_READ drops within the same cycle, BUSYWAIT=0. A later read of the same address misses again.
- Drive the hit counter to 0xFFFF via repeated hits -> it holds 0xFFFF on further hits; MISS_COUNT is unaffected.
